// File: rtl/seq_adder_pipeline.sv
// WIDTH-bit add / accumulate unit feeding a STAGES-deep registered result pipeline
// with a global stall enable, a valid flag that travels with the data, and a sticky overflow flag.
module seq_adder_pipeline #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             out_valid,
   output logic [WIDTH-1:0] acc_out,
   output logic             ovf_sticky
);

   logic [WIDTH-1:0] r_acc;
   logic             r_ovf;

   logic             w_accept;
   logic [WIDTH-1:0] w_base;
   logic [WIDTH-1:0] w_opb;
   logic [WIDTH:0]   w_res;

   assign w_accept = in_valid & en;
   // A clear on the same edge as an accumulate starts the new running sum from zero.
   assign w_base   = clr ? '0 : r_acc;
   assign w_opb    = mode ? w_base : b;
   assign w_res    = {1'b0, a} + {1'b0, w_opb};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (en) begin
         if (w_accept && mode)
            r_acc <= w_res[WIDTH-1:0];
         else if (clr)
            r_acc <= '0;

         if (w_accept)
            r_ovf <= (r_ovf & ~clr) | w_res[WIDTH];
         else if (clr)
            r_ovf <= 1'b0;
      end
   end

   assign acc_out    = r_acc;
   assign ovf_sticky = r_ovf;

   // Each stage only reloads its data on a valid result, so bubbles leave sum/carry untouched.
   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] w_in_sum;
      logic             w_in_cy;
      logic             w_in_vld;
      logic [WIDTH-1:0] r_sum;
      logic             r_cy;
      logic             r_vld;

      if (gi == 0) begin : g_head
         assign w_in_sum = w_res[WIDTH-1:0];
         assign w_in_cy  = w_res[WIDTH];
         assign w_in_vld = in_valid;
      end else begin : g_body
         assign w_in_sum = g_stage[gi-1].r_sum;
         assign w_in_cy  = g_stage[gi-1].r_cy;
         assign w_in_vld = g_stage[gi-1].r_vld;
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_sum <= '0;
            r_cy  <= 1'b0;
            r_vld <= 1'b0;
         end else if (en) begin
            r_vld <= w_in_vld;
            if (w_in_vld) begin
               r_sum <= w_in_sum;
               r_cy  <= w_in_cy;
            end
         end
      end
   end

   assign sum       = g_stage[STAGES-1].r_sum;
   assign carry     = g_stage[STAGES-1].r_cy;
   assign out_valid = g_stage[STAGES-1].r_vld;

endmodule

// File: tb/tb_seq_adder_pipeline.sv
// Scoreboard bench for seq_adder_pipeline (WIDTH=8, STAGES=2): directed ops push
// hand-computed results; a monitor pops one per newly presented output.
module tb_seq_adder_pipeline;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       mode;
   logic       clr;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] sum;
   logic       carry;
   logic       out_valid;
   logic [7:0] acc_out;
   logic       ovf_sticky;

   int n_cmp = 0;
   int n_err = 0;
   logic [8:0] exp_q[$];
   logic adv = 1'b0;

   seq_adder_pipeline #(.WIDTH(8), .STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .clr       (clr),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .sum       (sum),
      .carry     (carry),
      .out_valid (out_valid),
      .acc_out   (acc_out),
      .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   // A result is newly presented only after an edge that advanced the pipeline.
   always @(posedge clk) adv <= en & rst_n;

   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (out_valid && adv) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_result: got carry=%b sum=%h, required no output", carry, sum);
            end else begin
               e = exp_q.pop_front();
               if ({carry, sum} !== e) begin
                  n_err++;
                  $display("FAIL result: got carry=%b sum=%h, required carry=%b sum=%h",
                           carry, sum, e[8], e[7:0]);
               end else
                  $display("result ok: carry=%b sum=%h", carry, sum);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end else
         $display("check ok: %s = %h", name, act);
   endtask

   task automatic drive(input logic v, input logic m, input logic c, input logic e_in,
                        input logic [7:0] aa, input logic [7:0] bb);
      in_valid = v;
      mode     = m;
      clr      = c;
      en       = e_in;
      a        = aa;
      b        = bb;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] s, input logic cy);
      exp_q.push_back({cy, s});
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; en = 1'b1; mode = 1'b0; clr = 1'b0; in_valid = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_sum", 32'(sum), 32'h0);
      chk("rst_acc", 32'(acc_out), 32'h0);
      chk("rst_ovf", 32'(ovf_sticky), 32'h0);
      rst_n = 1'b1;

      // Reset mid-flight: first op emerges, second (with carry) is discarded.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 8'h00); push(8'h33, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h01);
      rst_n = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      chk("midrst_sum", 32'(sum), 32'h0);
      chk("midrst_carry", 32'(carry), 32'h0);
      chk("midrst_acc", 32'(acc_out), 32'h0);
      chk("midrst_ovf", 32'(ovf_sticky), 32'h0);
      repeat (3) idle();

      // Plain add with latency check.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 8'h01); push(8'h10, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat1_out_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      chk("lat2_out_valid", 32'(out_valid), 32'h1);
      chk("add_ovf", 32'(ovf_sticky), 32'h0);

      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h01); push(8'h00, 1'b1);
      in_valid = 1'b0;
      repeat (3) idle();
      @(negedge clk);
      chk("carry_ovf_sticky", 32'(ovf_sticky), 32'h1);

      // Five back-to-back accumulates of 0x40.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00); push(8'h40, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00); push(8'h80, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00); push(8'hC0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00); push(8'h00, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00); push(8'h40, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("accum_acc", 32'(acc_out), 32'h40);
      chk("accum_ovf", 32'(ovf_sticky), 32'h1);
      repeat (3) idle();

      // Stream of four adds with a three-cycle stall after the second accept.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 8'h22); push(8'h33, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hF0, 8'h20); push(8'h10, 1'b1);
      en = 1'b0; a = 8'hAA; b = 8'h55;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("stall_out_valid", 32'(out_valid), 32'h1);
         chk("stall_sum", 32'(sum), 32'h33);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h01); push(8'h80, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00); push(8'h00, 1'b0);
      repeat (3) idle();

      // Clear interplay with accumulate and stall.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 8'h00); push(8'h80, 1'b0);
      in_valid = 1'b0; clr = 1'b0;
      @(negedge clk);
      chk("clr_load_acc", 32'(acc_out), 32'h80);
      chk("clr_load_ovf", 32'(ovf_sticky), 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h01); push(8'h00, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("reset_ovf_set", 32'(ovf_sticky), 32'h1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("stall_clr_acc", 32'(acc_out), 32'h80);
      chk("stall_clr_ovf", 32'(ovf_sticky), 32'h1);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 8'h00); push(8'h05, 1'b0);
      in_valid = 1'b0; clr = 1'b0;
      @(negedge clk);
      chk("clr_op_acc", 32'(acc_out), 32'h05);
      chk("clr_op_ovf", 32'(ovf_sticky), 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80); push(8'h00, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      clr = 1'b0;
      @(negedge clk);
      chk("clr_only_acc", 32'(acc_out), 32'h00);
      chk("clr_only_ovf", 32'(ovf_sticky), 32'h0);

      repeat (4) idle();
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
